alu_sin_deserializer: RTL and testbench
=======================================

ALU_SIN_DESERIALIZER -- requirements
Module: alu_sin_deserializer

Interface
REQ-001 Port clk input 1: single clock; all sequential logic on posedge clk.
REQ-002 Port rst_n input 1: reset, asynchronous, active-low.
REQ-003 Port sin input 1: serial input; idle high; sampled on posedge clk.
REQ-004 Port a_out output 32: operand A, first four data frames, MSB byte first.
REQ-005 Port b_out output 32: operand B, next four data frames, MSB byte first.
REQ-006 Port op_out output 3: operation code from the command frame (operation_t).
REQ-007 Port out_valid output 1: one-cycle pulse; a_out/b_out/op_out hold a valid packet.
REQ-008 Port err_valid output 1: one-cycle pulse; err_flags is valid.
REQ-009 Port err_flags output 3: {err_data, err_crc, err_op}.

Function
REQ-010 Frame SHALL be 11 bits, MSB first: start(0), ctl, data[7:0], stop(1); ctl=0 data frame, ctl=1 command frame.
REQ-011 In IDLE, sin==0 sampled at posedge SHALL start a frame; the next 10 posedges SHALL sample ctl, data[7:0], stop.
REQ-012 States: IDLE (wait start), RECV (bit counter 1..10), CHECK (one cycle, evaluate packet); RECV->IDLE after stop bit of a data frame, RECV->CHECK after stop bit of a command frame or on any error.
REQ-013 A data-frame counter (0..8) SHALL increment per good data frame; frames 1-4 shift into A, 5-8 into B.
REQ-014 Command frame payload SHALL be {1'b0, op[2:0], crc[3:0]}.
REQ-015 CRC SHALL be CRC-4, polynomial x^4+x+1, init 0, over the 68-bit vector {A, B, 1'b1, op}, MSB first; computed serially per received bit or in parallel in CHECK, bit-exact to the package function.
REQ-016 err_data SHALL be set for: stop bit 0; command frame with counter != 8; ninth data frame.
REQ-017 err_crc SHALL be set when received crc != computed crc; err_op when op is not a defined operation_t value.
REQ-018 err_data SHALL suppress err_crc/err_op evaluation; err_crc and err_op MAY both be set.
REQ-019 In CHECK, no error: out_valid=1 for one cycle, a_out/b_out/op_out updated the same cycle, held until next good packet.
REQ-020 In CHECK, any error: err_valid=1 for one cycle with err_flags; a_out/b_out/op_out unchanged.
REQ-021 Latency: out_valid/err_valid SHALL assert in the cycle after the posedge sampling the offending/final stop bit.
REQ-022 After CHECK, counter and shift registers SHALL clear and FSM SHALL return to IDLE; a start bit sampled in the CHECK cycle SHALL be accepted (back-to-back packets).
REQ-023 err_flags SHALL be 0 whenever err_valid is 0.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, counters 0, a_out=0, b_out=0, op_out=0, out_valid=0, err_valid=0, err_flags=0.
REQ-025 Reset mid-frame or mid-packet SHALL discard partial data with no pulse; the first start bit after release begins a new packet.

Structure
REQ-026 Shared package alu_pkg SHALL hold operation_t (AND=3'b000, OR=3'b001, ADD=3'b100, SUB=3'b101), frame length 11, data-frame count 8, error-flag bit indices, and the CRC-4 function.
REQ-027 Sub-module alu_frame_rx SHALL handle single-frame reception (start detect, bit counter, stop check) returning {ctl, data, frame_ok, frame_err}; packet FSM stays in top.

Verification
REQ-028 ADD, A=32'h0000_0001, B=32'h0000_0002, correct CRC -> out_valid once, a_out=1, b_out=2, op_out=3'b100, err_valid never.
REQ-029 Same packet with crc bit 0 inverted -> err_valid, err_flags=3'b010, outputs keep previous values.
REQ-030 op=3'b111 with its correct CRC -> err_valid, err_flags=3'b001.
REQ-031 Command frame after 5 data frames -> err_valid, err_flags=3'b100; next good SUB packet A=5, B=3 -> out_valid, op_out=3'b101.
REQ-032 rst_n pulsed low during frame 6 -> outputs 0, no pulse; subsequent good AND packet A=32'hFFFF_0000, B=32'h0F0F_0F0F -> out_valid.
REQ-033 Two good packets back-to-back (start bit in CHECK cycle) -> two out_valid pulses, values of each packet.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU operand deserializer: operation codes,
// framing constants, error-flag positions and the packet CRC.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK
    } pkt_state_t;

    localparam int FRAME_LEN   = 11;
    localparam int DATA_FRAMES = 8;

    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    function automatic logic is_valid_op(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // CRC-4, x^4+x+1, init 0, MSB of the vector shifted in first.
    function automatic logic [3:0] crc4(input logic [67:0] vec);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ vec[i];
            c  = {c[2:0], 1'b0};
            if (fb) c = c ^ 4'b0011;
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// Single-frame receiver: detects the start bit, collects ctl + 8 data bits MSB
// first and reports the stop-bit outcome combinationally on the stop-bit edge.
module alu_frame_rx
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sin,
    output logic       o_start,
    output logic       o_ctl,
    output logic [7:0] o_data,
    output logic       o_frame_ok,
    output logic       o_frame_err
);

    localparam logic [3:0] STOP_IDX = 4'(FRAME_LEN - 1);

    logic [3:0] r_bit;
    logic [8:0] r_shift;
    logic       w_at_stop;

    // r_bit == 0 means idle; 1..9 sample ctl/data, STOP_IDX samples the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit <= '0;
        end else if (r_bit == '0) begin
            if (!i_sin) r_bit <= 4'd1;
        end else if (r_bit == STOP_IDX) begin
            r_bit <= '0;
        end else begin
            r_bit <= r_bit + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_bit != '0 && r_bit != STOP_IDX)
            r_shift <= {r_shift[7:0], i_sin};
    end

    assign w_at_stop   = (r_bit == STOP_IDX);
    assign o_start     = (r_bit == '0) && !i_sin;
    assign o_ctl       = r_shift[8];
    assign o_data      = r_shift[7:0];
    assign o_frame_ok  = w_at_stop && i_sin;
    assign o_frame_err = w_at_stop && !i_sin;

endmodule

// File: rtl/alu_sin_deserializer.sv
// Packet layer: eight data frames build operands A and B, a command frame
// carries op + CRC; the packet is validated and published on the final stop edge.
module alu_sin_deserializer
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [2:0]  op_out,
    output logic        out_valid,
    output logic        err_valid,
    output logic [2:0]  err_flags
);

    localparam logic [3:0] FULL_CNT = 4'(DATA_FRAMES);
    localparam logic [3:0] HALF_CNT = 4'(DATA_FRAMES / 2);

    pkt_state_t  r_state;
    pkt_state_t  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;

    logic        w_start;
    logic        w_ctl;
    logic [7:0]  w_data;
    logic        w_frame_ok;
    logic        w_frame_err;
    logic        w_done;
    logic [2:0]  w_op;
    logic [3:0]  w_crc_rx;
    logic        w_err_data;
    logic        w_err_crc;
    logic        w_err_op;
    logic [2:0]  w_flags;
    logic        w_to_check;
    logic        w_shift_in;

    alu_frame_rx u_frame_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sin       (sin),
        .o_start     (w_start),
        .o_ctl       (w_ctl),
        .o_data      (w_data),
        .o_frame_ok  (w_frame_ok),
        .o_frame_err (w_frame_err)
    );

    assign w_done   = w_frame_ok | w_frame_err;
    assign w_op     = w_data[6:4];
    assign w_crc_rx = w_data[3:0];

    // A framing/count problem makes the op and CRC fields meaningless, so it masks them.
    assign w_err_data = w_frame_err | (w_ctl ? (r_cnt != FULL_CNT) : (r_cnt == FULL_CNT));
    assign w_err_op   = !w_err_data && w_ctl && !is_valid_op(w_op);
    assign w_err_crc  = !w_err_data && w_ctl &&
                        (crc4({r_a, r_b, 1'b1, w_op}) != w_crc_rx);

    always_comb begin
        w_flags           = '0;
        w_flags[ERR_DATA] = w_err_data;
        w_flags[ERR_CRC]  = w_err_crc;
        w_flags[ERR_OP]   = w_err_op;
    end

    assign w_to_check = (r_state == ST_RECV) && w_done && (w_ctl || w_err_data);
    assign w_shift_in = (r_state == ST_RECV) && w_frame_ok && !w_ctl && (r_cnt != FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_nxt = ST_RECV;
            ST_RECV:  if (w_done)  w_state_nxt = w_to_check ? ST_CHECK : ST_IDLE;
            // A start bit seen during CHECK opens the next packet immediately.
            ST_CHECK: w_state_nxt = w_start ? ST_RECV : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (r_state == ST_CHECK) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_shift_in) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt < HALF_CNT) r_a <= {r_a[23:0], w_data};
            else                  r_b <= {r_b[23:0], w_data};
        end
    end

    // Results are registered on the final stop edge, so pulses coincide with CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out     <= '0;
            b_out     <= '0;
            op_out    <= '0;
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= '0;
        end else begin
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= '0;
            if (w_to_check) begin
                if (w_flags == '0) begin
                    out_valid <= 1'b1;
                    a_out     <= r_a;
                    b_out     <= r_b;
                    op_out    <= w_op;
                end else begin
                    err_valid <= 1'b1;
                    err_flags <= w_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sin_deserializer.sv
// Scoreboard bench for alu_sin_deserializer: expectations are queued when a
// packet's last stop bit is driven and checked when the DUT pulses.
module tb_alu_sin_deserializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [2:0]  op_out;
    logic        out_valid;
    logic        err_valid;
    logic [2:0]  err_flags;

    alu_sin_deserializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .a_out     (a_out),
        .b_out     (b_out),
        .op_out    (op_out),
        .out_valid (out_valid),
        .err_valid (err_valid),
        .err_flags (err_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        logic [2:0]  flags;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [2:0]  m_op = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference CRC by polynomial long division of msg * x^4 by 10011.
    function automatic logic [3:0] ref_crc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        logic [71:0] msg;
        logic [4:0]  rem;
        msg = {a, b, 1'b1, op, 4'b0000};
        rem = 5'b0;
        for (int i = 71; i >= 0; i--) begin
            rem = {rem[3:0], msg[i]};
            if (rem[4]) rem = rem ^ 5'b10011;
        end
        return rem[3:0];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sin = 1'b1;
        end
    endtask

    task automatic send_frame(input logic ctl, input logic [7:0] d, input logic stop);
        logic [10:0] f;
        f = {1'b0, ctl, d, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            sin = f[i];
        end
    endtask

    task automatic send_data(input logic [31:0] a, input logic [31:0] b, input int n);
        logic [7:0] byte_v;
        for (int i = 0; i < n; i++) begin
            if (i < 4)      byte_v = a[31 - 8*i -: 8];
            else if (i < 8) byte_v = b[31 - 8*(i-4) -: 8];
            else            byte_v = 8'hA5;
            send_frame(1'b0, byte_v, 1'b1);
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [3:0] crc);
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    // Called in the same time slot the final stop bit is driven.
    task automatic push_good(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        exp_t e;
        m_a = a;  m_b = b;  m_op = op;
        e.err = 1'b0;  e.flags = 3'b000;
        e.a = a;  e.b = b;  e.op = op;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [2:0] flags);
        exp_t e;
        e.err = 1'b1;  e.flags = flags;
        e.a = m_a;  e.b = m_b;  e.op = m_op;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic good_pkt(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input int gap);
        send_data(a, b, 8);
        send_cmd(op, ref_crc(a, b, op));
        push_good(a, b, op);
        if (gap > 0) idle(gap);
    endtask

    task automatic chk_hold();
        chk("hold_a", a_out, m_a);
        chk("hold_b", b_out, m_b);
        chk("hold_op", {29'b0, op_out}, {29'b0, m_op});
        chk("idle_flags", {29'b0, err_flags}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, a_out, 32'd0);
        chk({tag, "_b"}, b_out, 32'd0);
        chk({tag, "_op"}, {29'b0, op_out}, 32'd0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_err_valid"}, {31'b0, err_valid}, 32'd0);
        chk({tag, "_err_flags"}, {29'b0, err_flags}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (out_valid || err_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", {30'b0, out_valid, err_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind", {30'b0, out_valid, err_valid}, mon_e.err ? 32'd1 : 32'd2);
                chk("latency", cyc, mon_e.cyc);
                chk("err_flags", {29'b0, err_flags}, {29'b0, mon_e.flags});
                chk("a_out", a_out, mon_e.a);
                chk("b_out", b_out, mon_e.b);
                chk("op_out", {29'b0, op_out}, {29'b0, mon_e.op});
            end
        end
    end

    logic [2:0] ops [4] = '{3'b000, 3'b001, 3'b100, 3'b101};

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;

        rst_n = 1'b0;
        sin   = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        good_pkt(32'h0000_0001, 32'h0000_0002, 3'b100, 3);
        chk_hold();

        send_data(32'h0000_0001, 32'h0000_0002, 8);
        send_cmd(3'b100, ref_crc(32'h0000_0001, 32'h0000_0002, 3'b100) ^ 4'b0001);
        push_err(3'b010);
        idle(3);
        chk_hold();

        send_data(32'h1234_5678, 32'h9ABC_DEF0, 8);
        send_cmd(3'b111, ref_crc(32'h1234_5678, 32'h9ABC_DEF0, 3'b111));
        push_err(3'b001);
        idle(3);

        send_data(32'hCAFE_0001, 32'h0000_BEEF, 8);
        send_cmd(3'b110, ref_crc(32'hCAFE_0001, 32'h0000_BEEF, 3'b110) ^ 4'b1000);
        push_err(3'b011);
        idle(3);

        send_data(32'h0000_0001, 32'h0000_0002, 5);
        send_cmd(3'b100, 4'h0);
        push_err(3'b100);
        idle(3);
        good_pkt(32'h0000_0005, 32'h0000_0003, 3'b101, 3);
        chk_hold();

        send_data(32'h0000_0007, 32'h0000_0008, 9);
        push_err(3'b100);
        idle(3);
        chk_hold();

        send_data(32'h1111_2222, 32'h3333_4444, 1);
        send_frame(1'b0, 8'h3C, 1'b0);
        push_err(3'b100);
        idle(3);
        chk_hold();

        // Reset asserted partway through the sixth data frame.
        send_data(32'hDEAD_BEEF, 32'h0123_4567, 5);
        @(negedge clk); sin = 1'b0;
        @(negedge clk); sin = 1'b0;
        @(negedge clk); sin = 1'b1;
        @(negedge clk); sin = 1'b0;
        #3;
        rst_n = 1'b0;
        sin   = 1'b1;
        m_a = '0;  m_b = '0;  m_op = '0;
        @(negedge clk);
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        good_pkt(32'hFFFF_0000, 32'h0F0F_0F0F, 3'b000, 3);
        chk_hold();

        good_pkt(32'hA5A5_5A5A, 32'h8000_0001, 3'b001, 0);
        good_pkt(32'h7FFF_FFFF, 32'h0000_00FF, 3'b100, 3);
        chk_hold();

        for (int k = 0; k < 4; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = ops[$urandom_range(0, 3)];
            good_pkt(ra, rb, rop, 2);
        end
        idle(5);
        chk_hold();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
